cofre_temporizador: RTL and testbench
=====================================

# cofre_temporizador

Timing controller for the safe (cofre) lock state machine. It sits between the physical send button and the lock FSM's `B` input. It debounces the button, re-times it, and drives the FSM's `B` line. It also sequences two timed policies: an auto-relock pulse after the door has stayed open too long, and a penalty window that ignores the button after each wrong password.

## Interface
- `DEB_CICLOS`, 16: consecutive stable samples required to accept a button level change.
- `ABERTO_CICLOS`, 1000: cycles in AB (open) before auto-relock; must be ≥ 2.
- `PENAL_CICLOS`, 500: cycles the button is ignored after entering E1 or E2; must be ≥ 1.
- `CW`, derived as `$clog2(max(ABERTO_CICLOS, PENAL_CICLOS)+1)`: countdown width.

Ports:
- `clk`, in, 1: system clock; all logic on rising edge.
- `reset`, in, 1: asynchronous, active-low reset.
- `B_bruto`, in, 1: raw send button; 1 = released, 0 = pressed; asynchronous to `clk`.
- `estado_atual`, in, 3: lock FSM state (AB=000, AL=001, PF=010, FE=011, E1=100, E2=101, BL=110, EM=111).
- `B_out`, out, 1: registered button line to the lock FSM `B` input.
- `travado`, out, 1: 1 while the penalty window is active.
- `fechamento_auto`, out, 1: one-cycle strobe, high in the cycle `B_out` carries the auto-relock low.
- `contador_restante`, out, CW: active countdown value; 0 when idle.

## Operation
- Debounce path:
  - 2-flop synchronizer on `B_bruto`, producing `B_sinc`.
  - `B_estavel` takes the value of `B_sinc` after `B_sinc` has differed from it for `DEB_CICLOS` consecutive cycles.
  - Any agreeing sample clears the run counter.
- Entry detection: register `estado_visto` holds last cycle's `estado_atual`. An entry into X means `estado_atual==X && estado_visto!=X`.
- Controller FSM states are OCIOSO, ABERTO, PULSO and PENAL.
- OCIOSO:
  - `B_out`=`B_estavel`.
  - On entry into AB, go to ABERTO and load `ABERTO_CICLOS-1`.
  - On entry into E1 or E2, go to PENAL and load `PENAL_CICLOS-1`.
- ABERTO:
  - `B_out`=`B_estavel`; count down by 1 per cycle.
  - If `estado_atual`!=AB, go to OCIOSO and clear the counter.
  - At count 0 with `B_estavel`=1, go to PULSO.
  - At count 0 with `B_estavel`=0 (button held), hold at 0 and wait for release, so the FSM always sees a 1→0 edge.
- PULSO:
  - `B_out`=0 and `fechamento_auto`=1 for exactly one cycle, then go to OCIOSO.
  - Because OCIOSO reacts only to entries, a lingering AB does not re-arm the timer.
- PENAL:
  - `B_out` is forced to 1 and `travado`=1; count down.
  - At count 0, go to OCIOSO.
  - If `estado_atual` leaves {E1,E2} first, go to OCIOSO immediately.
- Priority when events coincide: reset > state-exit check > countdown expiry > entry detection.
- BL and EM get no timing action; the button passes through in OCIOSO.
- `contador_restante` mirrors the active countdown and is 0 in OCIOSO and PULSO.

## Timing
- Reset values:
  - `B_out`=1, `travado`=0, `fechamento_auto`=0, `contador_restante`=0.
  - Controller in OCIOSO; `estado_visto`=FE (011).
  - `B_estavel`=1; synchronizer flops are 1.
- Press latency: an edge on `B_bruto` reaches `B_out` after 2 (sync) + `DEB_CICLOS` + 1 (output register) cycles.
- Auto-relock: the `B_out` low occurs `ABERTO_CICLOS`+1 cycles after the first cycle `estado_atual`=AB. The FSM then leaves AB on the following edge.
- Penalty: `B_out` is held at 1 from the cycle after entry into E1/E2 for `PENAL_CICLOS` cycles.
  - A press that is still held at the end of the window appears as a fresh falling edge once `B_out` returns to `B_estavel`.
- Reset mid-countdown: all state clears asynchronously; after release the controller restarts in OCIOSO with no pending pulse.

## Structure
- Shared package `cofre_pkg`:
  - lock-state encodings (AB…EM, 3-bit localparams);
  - controller state encoding (2-bit: OCIOSO=00, ABERTO=01, PULSO=10, PENAL=11).
- Sub-module `cofre_debounce` (synchronizer + run counter, parameter `DEB_CICLOS`), instanced once. Counters and controller FSM live in the top.

## Test plan
- `DEB_CICLOS`=4, `B_bruto` glitches low for 3 cycles -> `B_out` stays 1. Held low for 10 cycles -> `B_out` falls 7 cycles after the press edge.
- `ABERTO_CICLOS`=8, `estado_atual` forced to AB -> `B_out`=0 and `fechamento_auto`=1 for one cycle, 9 cycles after entry; `contador_restante` steps 7…0.
- Same as above, but `B_estavel` is 0 at expiry -> counter holds at 0; the pulse issues on the cycle after `B_out` returns to 1.
- `PENAL_CICLOS`=5, `estado_atual` FE→E1, presses during the window -> `travado`=1 and `B_out`=1 for 5 cycles; afterwards a press passes through.
- In PENAL, `estado_atual` jumps to AB at count 3 -> immediate return to OCIOSO; the next AB entry arms ABERTO.
- `reset`=0 asserted in ABERTO at count 2 -> all outputs return to their reset values asynchronously; no pulse follows release.

Source files
------------

// File: rtl/cofre_pkg.sv
// Shared encodings for the safe lock FSM and its timing controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cofre_pkg;

    // Lock FSM state encodings as seen on estado_atual
    localparam logic [2:0] EST_AB = 3'b000;
    localparam logic [2:0] EST_AL = 3'b001;
    localparam logic [2:0] EST_PF = 3'b010;
    localparam logic [2:0] EST_FE = 3'b011;
    localparam logic [2:0] EST_E1 = 3'b100;
    localparam logic [2:0] EST_E2 = 3'b101;
    localparam logic [2:0] EST_BL = 3'b110;
    localparam logic [2:0] EST_EM = 3'b111;

    // Timing controller states
    typedef enum logic [1:0] {
        OCIOSO = 2'b00,
        ABERTO = 2'b01,
        PULSO  = 2'b10,
        PENAL  = 2'b11
    } ctrl_est_t;

    // Countdown width: wide enough for the larger of the two timer loads
    function automatic int cw_calc(input int aberto, input int penal);
        return $clog2(((aberto > penal) ? aberto : penal) + 1);
    endfunction

endpackage

// File: rtl/cofre_temporizador_if.sv
// Bundle between the button/lock FSM side and the timing controller.
// Latency: n/a (wires only).
// Backpressure: none; all signals are level/strobe lines.
// Ports: B_bruto, estado_atual (into controller); B_out, travado,
//        fechamento_auto, contador_restante (out of controller).
interface cofre_temporizador_if #(
    parameter int CW = 10
);
    logic          B_bruto;
    logic [2:0]    estado_atual;
    logic          B_out;
    logic          travado;
    logic          fechamento_auto;
    logic [CW-1:0] contador_restante;

    // master: the environment (button + lock FSM)
    modport master (
        output B_bruto,
        output estado_atual,
        input  B_out,
        input  travado,
        input  fechamento_auto,
        input  contador_restante
    );

    // slave: the timing controller
    modport slave (
        input  B_bruto,
        input  estado_atual,
        output B_out,
        output travado,
        output fechamento_auto,
        output contador_restante
    );
endinterface

// File: rtl/cofre_debounce.sv
// Synchronizes and debounces the raw send button (1 = released).
// Latency: 2 sync cycles + DEB_CICLOS stable samples before b_estavel moves.
// Backpressure: none; glitches shorter than DEB_CICLOS are swallowed.
// Ports: clk, rst_n (async low), b_bruto (raw, async), b_estavel (clean level).
module cofre_debounce #(
    parameter int DEB_CICLOS = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic b_bruto,
    output logic b_estavel
);

    localparam int RW = $clog2(DEB_CICLOS + 1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          estavel_q, estavel_d;
    logic [RW-1:0] run_q, run_d;

    always_comb begin
        sync1_d   = b_bruto;
        sync2_d   = sync1_q;
        estavel_d = estavel_q;
        run_d     = '0;
        if (sync2_q != estavel_q) begin
            // The DEB_CICLOS-th consecutive differing sample flips the level
            if (run_q == RW'(DEB_CICLOS - 1)) begin
                estavel_d = sync2_q;
                run_d     = '0;
            end else begin
                run_d = run_q + RW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            estavel_q <= 1'b1;
            run_q     <= '0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            estavel_q <= estavel_d;
            run_q     <= run_d;
        end
    end

    assign b_estavel = estavel_q;

endmodule

// File: rtl/cofre_temporizador.sv
// Drives the lock FSM B input: debounced button, auto-relock pulse, penalty lockout.
// Latency: button edge -> B_out in 2 + DEB_CICLOS + 1 cycles; relock low ABERTO_CICLOS+1 after AB.
// Backpressure: button ignored (B_out=1) during penalty; relock waits for a released button.
// Ports: clk, reset (async low), io (slave modport: B_bruto, estado_atual in;
//        B_out, travado, fechamento_auto, contador_restante out).
module cofre_temporizador
    import cofre_pkg::*;
#(
    parameter int DEB_CICLOS    = 16,
    parameter int ABERTO_CICLOS = 1000,
    parameter int PENAL_CICLOS  = 500,
    localparam int CW           = cw_calc(ABERTO_CICLOS, PENAL_CICLOS)
) (
    input  logic                  clk,
    input  logic                  reset,
    cofre_temporizador_if.slave   io
);

    localparam logic [CW-1:0] ABERTO_INI = CW'(ABERTO_CICLOS - 1);
    localparam logic [CW-1:0] PENAL_INI  = CW'(PENAL_CICLOS - 1);

    logic b_estavel;

    cofre_debounce #(
        .DEB_CICLOS (DEB_CICLOS)
    ) u_debounce (
        .clk       (clk),
        .rst_n     (reset),
        .b_bruto   (io.B_bruto),
        .b_estavel (b_estavel)
    );

    ctrl_est_t     st_q, st_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    estado_visto_q, estado_visto_d;
    logic          b_out_q, b_out_d;
    logic          travado_q, travado_d;
    logic          fech_q, fech_d;

    logic ent_ab;
    logic ent_erro;
    logic em_erro;

    always_comb begin
        ent_ab   = (io.estado_atual == EST_AB) && (estado_visto_q != EST_AB);
        ent_erro = ((io.estado_atual == EST_E1) && (estado_visto_q != EST_E1)) ||
                   ((io.estado_atual == EST_E2) && (estado_visto_q != EST_E2));
        em_erro  = (io.estado_atual == EST_E1) || (io.estado_atual == EST_E2);
    end

    // Next state / counter. Exit checks come first, then expiry; entries are
    // only acted on from OCIOSO, so a lingering AB never re-arms the timer.
    always_comb begin
        st_d           = st_q;
        cnt_d          = cnt_q;
        estado_visto_d = io.estado_atual;
        unique case (st_q)
            OCIOSO: begin
                if (ent_ab) begin
                    st_d  = ABERTO;
                    cnt_d = ABERTO_INI;
                end else if (ent_erro) begin
                    st_d  = PENAL;
                    cnt_d = PENAL_INI;
                end
            end
            ABERTO: begin
                if (io.estado_atual != EST_AB) begin
                    st_d  = OCIOSO;
                    cnt_d = '0;
                end else if (cnt_q == '0) begin
                    // Only fire once the lock FSM has actually seen B high,
                    // so the pulse is always a genuine 1->0 edge.
                    if (b_estavel && b_out_q) begin
                        st_d = PULSO;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            PULSO: begin
                st_d  = OCIOSO;
                cnt_d = '0;
            end
            PENAL: begin
                if (!em_erro) begin
                    st_d  = OCIOSO;
                    cnt_d = '0;
                end else if (cnt_q == '0) begin
                    st_d = OCIOSO;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                st_d  = OCIOSO;
                cnt_d = '0;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with st_q
    always_comb begin
        b_out_d   = b_estavel;
        travado_d = 1'b0;
        fech_d    = 1'b0;
        unique case (st_d)
            PULSO: begin
                b_out_d = 1'b0;
                fech_d  = 1'b1;
            end
            PENAL: begin
                b_out_d   = 1'b1;
                travado_d = 1'b1;
            end
            default: begin
                b_out_d = b_estavel;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st_q           <= OCIOSO;
            cnt_q          <= '0;
            estado_visto_q <= EST_FE;
            b_out_q        <= 1'b1;
            travado_q      <= 1'b0;
            fech_q         <= 1'b0;
        end else begin
            st_q           <= st_d;
            cnt_q          <= cnt_d;
            estado_visto_q <= estado_visto_d;
            b_out_q        <= b_out_d;
            travado_q      <= travado_d;
            fech_q         <= fech_d;
        end
    end

    assign io.B_out             = b_out_q;
    assign io.travado           = travado_q;
    assign io.fechamento_auto   = fech_q;
    assign io.contador_restante = cnt_q;

endmodule

// File: tb/tb_cofre_temporizador.sv
// Bench for cofre_temporizador with DEB=4, ABERTO=8, PENAL=5.
// Latency: n/a.
// Backpressure: n/a.
module tb_cofre_temporizador;
    import cofre_pkg::*;

    localparam int DEB = 4;
    localparam int ABR = 8;
    localparam int PEN = 5;
    localparam int CW  = cw_calc(ABR, PEN);

    logic clk;
    logic reset;

    cofre_temporizador_if #(.CW(CW)) bus ();

    cofre_temporizador #(
        .DEB_CICLOS    (DEB),
        .ABERTO_CICLOS (ABR),
        .PENAL_CICLOS  (PEN)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .io    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          bb;
        logic [2:0]    est;
        logic          eb;
        logic          et;
        logic          ef;
        logic [CW-1:0] ec;
    } vec_t;

    vec_t vecs[$];
    int   checks;
    int   errors;

    task automatic add(input logic bb, input logic [2:0] est, input logic eb,
                       input logic et, input logic ef, input int ec);
        vec_t v;
        v.bb  = bb;
        v.est = est;
        v.eb  = eb;
        v.et  = et;
        v.ef  = ef;
        v.ec  = CW'(ec);
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input logic eb, input logic et,
                       input logic ef, input int ec);
        checks++;
        if (bus.B_out !== eb || bus.travado !== et ||
            bus.fechamento_auto !== ef || bus.contador_restante !== CW'(ec)) begin
            errors++;
            $display("FAIL %s: got B_out=%b travado=%b fech=%b cnt=%0d, want B_out=%b travado=%b fech=%b cnt=%0d",
                     nm, bus.B_out, bus.travado, bus.fechamento_auto,
                     bus.contador_restante, eb, et, ef, ec);
        end
    endtask

    // Drive inputs, let one rising edge sample them, settle past the edge
    task automatic step(input logic bb, input logic [2:0] est);
        bus.B_bruto      = bb;
        bus.estado_atual = est;
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;

        // ---- vector table ----
        // Debounce: 3-cycle glitch is swallowed
        for (int i = 0; i < 3; i++) add(0, EST_AL, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) add(1, EST_AL, 1, 0, 0, 0);
        // Held press: B_out falls on the 7th edge after the press
        for (int h = 1; h <= 10; h++) add(0, EST_AL, (h < 7) ? 1'b1 : 1'b0, 0, 0, 0);
        // Release: B_out rises on the 7th edge after release
        for (int h = 1; h <= 7; h++) add(1, EST_AL, (h < 7) ? 1'b0 : 1'b1, 0, 0, 0);
        // Auto-relock: counter 7..0, pulse on 9th edge, lingering AB no re-arm
        for (int k = 0; k < 8; k++) add(1, EST_AB, 1, 0, 0, 7 - k);
        add(1, EST_AB, 0, 0, 1, 0);
        add(1, EST_AB, 1, 0, 0, 0);
        add(1, EST_AB, 1, 0, 0, 0);
        add(1, EST_AL, 1, 0, 0, 0);
        // Penalty: press during window is masked, then shows as a fresh edge
        add(1, EST_FE, 1, 0, 0, 0);
        for (int k = 1; k <= 5; k++) add(0, EST_E1, 1, 1, 0, 5 - k);
        add(0, EST_E1, 1, 0, 0, 0);
        add(0, EST_E1, 0, 0, 0, 0);
        for (int k = 8; k <= 13; k++) add(1, EST_E1, 0, 0, 0, 0);
        add(1, EST_E1, 1, 0, 0, 0);

        // ---- reset ----
        reset            = 1'b1;
        bus.B_bruto      = 1'b1;
        bus.estado_atual = EST_FE;
        #1;
        reset = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("reset", 1, 0, 0, 0);
        @(negedge clk);
        reset = 1'b1;
        step(1, EST_FE);
        chk("post_reset_idle", 1, 0, 0, 0);

        // ---- table ----
        foreach (vecs[i]) begin
            step(vecs[i].bb, vecs[i].est);
            chk($sformatf("vec%0d", i), vecs[i].eb, vecs[i].et, vecs[i].ef, vecs[i].ec);
        end

        // ---- button held at expiry: counter parks at 0, pulse after release ----
        step(1, EST_AL);
        chk("held_pre", 1, 0, 0, 0);
        for (int k = 1; k <= 21; k++) begin
            logic eb;
            eb = (k < 7) ? 1'b1 : (k <= 18) ? 1'b0 : (k == 20) ? 1'b0 : 1'b1;
            step((k <= 12) ? 1'b0 : 1'b1, EST_AB);
            chk($sformatf("held_k%0d", k), eb, 0, (k == 20) ? 1'b1 : 1'b0,
                (k <= 8) ? 8 - k : 0);
        end
        step(1, EST_AL);
        chk("held_post", 1, 0, 0, 0);

        // ---- penalty exit to AB at count 3 ----
        step(1, EST_E1);
        chk("jump_c4", 1, 1, 0, 4);
        step(1, EST_E1);
        chk("jump_c3", 1, 1, 0, 3);
        step(1, EST_AB);
        chk("jump_exit", 1, 0, 0, 0);
        step(1, EST_AB);
        chk("jump_no_arm", 1, 0, 0, 0);
        step(1, EST_FE);
        chk("jump_fe", 1, 0, 0, 0);
        step(1, EST_AB);
        chk("jump_rearm7", 1, 0, 0, 7);
        step(1, EST_AB);
        chk("jump_rearm6", 1, 0, 0, 6);

        // ---- async reset at count 2 ----
        for (int k = 5; k >= 2; k--) begin
            step(1, EST_AB);
            chk($sformatf("rst_pre_c%0d", k), 1, 0, 0, k);
        end
        #2;
        reset            = 1'b0;
        bus.estado_atual = EST_AL;
        #1;
        chk("rst_async", 1, 0, 0, 0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 12; k++) begin
            step(1, EST_AL);
            chk($sformatf("rst_after%0d", k), 1, 0, 0, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
